nibble_serial_adder_ctrl: RTL and testbench

- Sequencer that time-multiplexes one external combinational 4-bit full adder (a, b, cin → sum, carry) to add wide operands.
- Processes one nibble per clock, LSB first, and feeds the carry back between nibbles.
- Accepts a wide operand pair through a valid/ready handshake and returns the wide sum through a second valid/ready handshake.
- Sits between any wide-add requester and the shared 4-bit adder instance.

---
 rtl/nibble_serial_adder_ctrl.sv | 85 ++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds wide operands one nibble per clock through a shared external 4-bit adder.
// Optional SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W = 4*NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         op_cin,
   output logic [3:0]   add_a,
   output logic [3:0]   add_b,
   output logic         add_cin,
   input  logic [3:0]   add_sum,
   input  logic         add_carry,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         busy
`ifdef SERIAL_ADD_OVF_EN
   ,output logic        ovf
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [W-1:0] a_sh, b_sh;
   logic carry_reg;
   logic [4:0] cnt;
   logic last;
   assign last = cnt == 5'(NIBBLES-1);
   // operand shifters drain to zero by DONE, so the adder inputs idle at 0 without extra gating
   assign add_a = a_sh[3:0];
   assign add_b = b_sh[3:0];
   assign add_cin = (state == RUN) && carry_reg;
   assign start_ready = state == IDLE;
   assign res_valid = state == DONE;
   assign busy = state != IDLE;
   assign cout = carry_reg;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_sh <= '0;
         b_sh <= '0;
         carry_reg <= 1'b0;
         cnt <= '0;
         result <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start_valid) begin
               a_sh <= op_a;
               b_sh <= op_b;
               carry_reg <= op_cin;
               cnt <= '0;
               result <= '0;
`ifdef SERIAL_ADD_OVF_EN
               ovf <= 1'b0;
`endif
               state <= RUN;
            end
            RUN: begin
               result <= {add_sum, result[W-1:4]};
               carry_reg <= add_carry;
               a_sh <= a_sh >> 4;
               b_sh <= b_sh >> 4;
               cnt <= cnt + 5'd1;
               if (last) begin
                  state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
                  ovf <= (add_a[3] == add_b[3]) && (add_sum[3] != add_a[3]);
`endif
               end
            end
            DONE: if (res_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: scoreboard bench with a behavioural 4-bit adder attached to the controller.
module tb_nibble_serial_adder_ctrl;
   localparam int NIB = 4;
   localparam int W = 4*NIB;
   typedef struct packed {logic [W-1:0] res; logic co;} exp_t;
   logic clk = 0, rst = 1;
   logic start_valid = 0, start_ready, op_cin = 0, res_ready = 1;
   logic [W-1:0] op_a = '0, op_b = '0, result;
   logic [3:0] add_a, add_b, add_sum;
   logic add_cin, add_carry, res_valid, cout, busy;
`ifdef SERIAL_ADD_OVF_EN
   logic ovf;
`endif
   exp_t sb[$];
   int errors = 0, checks = 0;

   always #5 clk = ~clk;
   assign {add_carry, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
      .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .add_a(add_a), .add_b(add_b),
      .add_cin(add_cin), .add_sum(add_sum), .add_carry(add_carry),
      .res_valid(res_valid), .res_ready(res_ready), .result(result), .cout(cout),
      .busy(busy)
`ifdef SERIAL_ADD_OVF_EN
      , .ovf(ovf)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every result handshake is matched against the oldest expectation
   always @(negedge clk) begin
      if (res_valid && res_ready) begin
         if (sb.size() == 0) check("unexpected_result", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("cout", 32'(cout), 32'(e.co));
         end
      end
   end

   task automatic reset_vals(input string tag);
      check({tag, "_start_ready"}, 32'(start_ready), 1);
      check({tag, "_res_valid"}, 32'(res_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_result"}, 32'(result), 0);
      check({tag, "_cout"}, 32'(cout), 0);
      check({tag, "_add"}, {23'd0, add_a, add_b, add_cin}, 0);
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 0);
`endif
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!start_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("start_ready_timeout", 32'(start_ready), 1);
   endtask

   task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int hold);
      logic [W:0] full;
      logic c;
      logic [4:0] s;
      full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      wait_ready();
      op_a = a; op_b = b; op_cin = cin; start_valid = 1; res_ready = (hold == 0);
      sb.push_back({full[W-1:0], full[W]});
      @(posedge clk); #1;
      start_valid = 0;
      check("accept_busy", 32'(busy), 1);
      check("accept_start_ready", 32'(start_ready), 0);
`ifdef SERIAL_ADD_OVF_EN
      check("ovf_cleared", 32'(ovf), 0);
`endif
      c = cin;
      for (int i = 0; i < NIB; i++) begin
         check("add_a", 32'(add_a), 32'(a[4*i +: 4]));
         check("add_b", 32'(add_b), 32'(b[4*i +: 4]));
         check("add_cin", 32'(add_cin), 32'(c));
         check("early_valid", 32'(res_valid), 0);
         s = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(c);
         c = s[4];
         @(posedge clk); #1;
      end
      check("latency_valid", 32'(res_valid), 1);
      check("done_add_idle", {27'd0, add_a, add_cin}, 0);
`ifdef SERIAL_ADD_OVF_EN
      check("ovf", 32'(ovf), 32'((a[W-1] == b[W-1]) && (full[W-1] != a[W-1])));
`endif
      if (hold > 0) begin
         op_a = 16'hAAAA; op_b = 16'h5555; start_valid = 1;
         for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(res_valid), 1);
            check("hold_result", 32'(result), 32'(full[W-1:0]));
            check("hold_start_ready", 32'(start_ready), 0);
            @(posedge clk); #1;
         end
         res_ready = 1;
         @(posedge clk); #1;
         check("post_done_idle", 32'(start_ready), 1);
         check("post_done_not_accepted", 32'(busy), 0);
         start_valid = 0;
      end else begin
         @(posedge clk); #1;
         check("post_done_idle", 32'(start_ready), 1);
         check("post_done_valid", 32'(res_valid), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      #12;
      reset_vals("reset");
      rst = 0;
      @(posedge clk); #1;
      do_add(16'h1234, 16'h0FFF, 0, 0);
      do_add(16'hFFFF, 16'h0001, 0, 0);
      do_add(16'h0002, 16'h000A, 1, 0);
      do_add(16'h8000, 16'h8000, 1, 0);
      do_add(16'h1234, 16'h4321, 0, 5);
      do_add(16'h7FFF, 16'h0001, 0, 0);
      // abort a transfer after two RUN edges
      wait_ready();
      op_a = 16'h1234; op_b = 16'h1111; op_cin = 1; start_valid = 1;
      @(posedge clk); #1;
      start_valid = 0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1; #1;
      reset_vals("midrun_reset");
      #1 rst = 0;
      repeat (6) begin
         @(posedge clk); #1;
         check("no_valid_after_reset", 32'(res_valid), 0);
      end
      do_add(16'h0003, 16'h0006, 0, 0);
      repeat (3) @(posedge clk);
      #1 check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
